// File: rtl/disp_mux_sched.sv
// Round-robin scheduler sharing one 2-digit 7-seg decoder among 4 sources.
// Optional sticky ">99" flags enabled by macro OVF_STICKY_EN; all outputs registered.
module disp_mux_sched #(
  parameter int DWELL     = 50_000_000,
  parameter int BLANK_CYC = 2,
  parameter int CW        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] val0,
  input  logic [6:0] val1,
  input  logic [6:0] val2,
  input  logic [6:0] val3,
  input  logic [3:0] valid,
  input  logic       hold,
  input  logic       next,
  input  logic       clr_ovf,
  output logic [6:0] bin_out,
  output logic [1:0] chan,
  output logic [3:0] chan_led,
  output logic       blank,
  output logic [3:0] ovf
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

  state_t          state_q, state_d;
  logic [1:0]      chan_q, chan_d;
  logic [6:0]      bin_out_q, bin_out_d;
  logic [3:0]      chan_led_q, chan_led_d;
  logic            blank_q, blank_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [6:0]      val_sel;
  logic [1:0]      nxt_chan;

  // Scan chan+1, chan+2, chan+3, then chan itself; first valid index wins.
  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] c);
    logic [1:0] idx;
    pick = c;
    for (int k = 4; k >= 1; k--) begin
      idx = c + 2'(k);
      if (v[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    case (chan_q)
      2'd0:    val_sel = val0;
      2'd1:    val_sel = val1;
      2'd2:    val_sel = val2;
      default: val_sel = val3;
    endcase
  end

  assign nxt_chan = pick(valid, chan_q);

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bin_out_d   = bin_out_q;
    chan_led_d  = chan_led_q;
    blank_d     = blank_q;
    cnt_d       = cnt_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      IDLE: begin
        if (valid != 4'b0000) begin
          chan_d  = nxt_chan;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bin_out_d  = val_sel;
        cnt_d      = '0;
        chan_led_d = 4'b0001 << chan_q;
        blank_d    = 1'b0;
        state_d    = SHOW;
      end
      SHOW: begin
        if ((cnt_q == CW'(DWELL - 1) && !hold) || next || !valid[chan_q]) begin
          chan_led_d = 4'b0000;
          blank_d    = 1'b1;
          if (valid == 4'b0000) begin
            state_d = IDLE;
          end else begin
            chan_d      = nxt_chan;
            blank_cnt_d = '0;
            state_d     = (BLANK_CYC > 0) ? BLANK : LOAD;
          end
        end else if (!hold) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (valid == 4'b0000) begin
          state_d = IDLE;
        end else if (int'(blank_cnt_q) >= BLANK_CYC - 1) begin
          state_d = LOAD;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      chan_q      <= 2'd0;
      bin_out_q   <= 7'd0;
      chan_led_q  <= 4'b0000;
      blank_q     <= 1'b1;
      cnt_q       <= '0;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      bin_out_q   <= bin_out_d;
      chan_led_q  <= chan_led_d;
      blank_q     <= blank_d;
      cnt_q       <= cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign bin_out  = bin_out_q;
  assign chan     = chan_q;
  assign chan_led = chan_led_q;
  assign blank    = blank_q;

`ifdef OVF_STICKY_EN
  logic [3:0] ovf_q, ovf_d;

  // A set on the LOAD edge beats a simultaneous clear for the same bit.
  always_comb begin
    ovf_d = clr_ovf ? 4'b0000 : ovf_q;
    if (state_q == LOAD && val_sel > 7'd99) ovf_d[chan_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 4'b0000;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign ovf            = 4'b0000;
`endif

endmodule

// File: tb/tb_disp_mux_sched.sv
// Bench for disp_mux_sched with DWELL=4, BLANK_CYC=1; vector table plus hand sequences.
module tb_disp_mux_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] val0 = '0, val1 = '0, val2 = '0, val3 = '0;
  logic [3:0] valid = '0;
  logic       hold = 1'b0, next = 1'b0, clr_ovf = 1'b0;
  logic [6:0] bin_out;
  logic [1:0] chan;
  logic [3:0] chan_led;
  logic       blank;
  logic [3:0] ovf;

`ifdef OVF_STICKY_EN
  localparam logic [3:0] OVF1 = 4'b0010;
`else
  localparam logic [3:0] OVF1 = 4'b0000;
`endif

  disp_mux_sched #(.DWELL(4), .BLANK_CYC(1), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .valid(valid), .hold(hold), .next(next), .clr_ovf(clr_ovf),
    .bin_out(bin_out), .chan(chan), .chan_led(chan_led), .blank(blank), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] bin;
    logic [1:0] ch;
    logic [3:0] led;
    logic       blk;
    logic [3:0] ovf;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [6:0] v0, v1, v2;
    logic       hold, nxt, clr;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] vl, input int v0, input int v1,
                              input int v2, input logic h, input logic n, input logic c,
                              input int b, input int ch, input int led, input logic blk,
                              input logic [3:0] o);
    vec_t v;
    v.rst = rst; v.valid = vl; v.v0 = 7'(v0); v.v1 = 7'(v1); v.v2 = 7'(v2);
    v.hold = h; v.nxt = n; v.clr = c;
    v.e.bin = 7'(b); v.e.ch = 2'(ch); v.e.led = 4'(led); v.e.blk = blk; v.e.ovf = o;
    return v;
  endfunction

  task automatic add(input logic [3:0] vl, input int v0, input int v2, input logic h,
                     input logic n, input int b, input int ch, input int led, input logic blk);
    tbl.push_back(mk(1'b0, vl, v0, 0, v2, h, n, 1'b0, b, ch, led, blk, 4'b0000));
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    reset = v.rst; valid = v.valid; val0 = v.v0; val1 = v.v1; val2 = v.v2;
    hold = v.hold; next = v.nxt; clr_ovf = v.clr;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " bin_out"},  int'(bin_out),  int'(e.bin));
    chk({tag, " chan"},     int'(chan),     int'(e.ch));
    chk({tag, " chan_led"}, int'(chan_led), int'(e.led));
    chk({tag, " blank"},    int'(blank),    int'(e.blk));
    chk({tag, " ovf"},      int'(ovf),      int'(e.ovf));
  endtask

  initial begin
    // Alternating channels 2 and 0, hold/next, value change, valid drops
    add(4'b0101, 12, 87, 0, 0,  0, 2, 0, 1);
    add(4'b0101, 12, 87, 0, 0, 87, 2, 4, 0);
    for (int i = 0; i < 3; i++) add(4'b0101, 12, 87, 0, 0, 87, 2, 4, 0);
    add(4'b0101, 12, 87, 0, 0, 87, 0, 0, 1);
    add(4'b0101, 12, 87, 0, 0, 87, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(4'b0101, 12, 87, 0, 0, 12, 0, 1, 0);
    add(4'b0101, 12, 87, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 87, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 87, 0, 0, 87, 2, 4, 0);
    for (int i = 0; i < 20; i++) add(4'b0101, 12, 87, 1, 0, 87, 2, 4, 0);
    add(4'b0101, 12, 87, 1, 1, 87, 0, 0, 1);
    add(4'b0101, 12, 87, 1, 1, 87, 0, 0, 1);
    add(4'b0101, 12, 87, 0, 1, 12, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(4'b0101, 12, 87, 0, 0, 12, 0, 1, 0);
    add(4'b0101, 12, 87, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 87, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 87, 0, 0, 87, 2, 4, 0);
    for (int i = 0; i < 3; i++) add(4'b0101, 12, 45, 0, 0, 87, 2, 4, 0);
    add(4'b0101, 12, 45, 0, 0, 87, 0, 0, 1);
    add(4'b0101, 12, 45, 0, 0, 87, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(4'b0101, 12, 45, 0, 0, 12, 0, 1, 0);
    add(4'b0101, 12, 45, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 45, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 45, 0, 0, 45, 2, 4, 0);
    add(4'b0001, 12, 45, 0, 0, 45, 0, 0, 1);
    add(4'b0001, 12, 45, 0, 0, 45, 0, 0, 1);
    add(4'b0001, 12, 45, 0, 0, 12, 0, 1, 0);
    add(4'b0000, 12, 45, 0, 0, 12, 0, 0, 1);
    add(4'b0000, 12, 45, 0, 0, 12, 0, 0, 1);
    add(4'b0101, 12, 45, 0, 0, 12, 2, 0, 1);
    add(4'b0101, 12, 45, 0, 0, 45, 2, 4, 0);
    add(4'b0101, 12, 45, 0, 1, 45, 0, 0, 1);
    add(4'b0000, 12, 45, 0, 0, 45, 0, 0, 1);
    add(4'b0000, 12, 45, 0, 0, 45, 0, 0, 1);
    // Single valid channel: dwell expiry re-selects it and re-latches its value
    add(4'b0100, 12, 45, 0, 0, 45, 2, 0, 1);
    add(4'b0100, 12, 45, 0, 0, 45, 2, 4, 0);
    for (int i = 0; i < 3; i++) add(4'b0100, 12, 33, 0, 0, 45, 2, 4, 0);
    add(4'b0100, 12, 33, 0, 0, 45, 2, 0, 1);
    add(4'b0100, 12, 33, 0, 0, 45, 2, 0, 1);
    add(4'b0100, 12, 33, 0, 0, 33, 2, 4, 0);

    @(posedge clk);
    #1;
    run_vec("reset", mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));
    for (int i = 0; i < 10; i++)
      run_vec($sformatf("idle%0d", i), mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));

    foreach (tbl[i]) run_vec($sformatf("row%0d", i), tbl[i]);

    // Sticky overflow flag on channel 1, clear, set-beats-clear, reset mid-show
    run_vec("ovf_rst",  mk(1, 4'b0000, 0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 4'b0000));
    run_vec("ovf_idle", mk(0, 4'b0010, 0, 120, 0, 0, 0, 0,   0, 1, 0, 1, 4'b0000));
    run_vec("ovf_load", mk(0, 4'b0010, 0, 120, 0, 0, 0, 0, 120, 1, 2, 0, OVF1));
    for (int i = 0; i < 3; i++)
      run_vec($sformatf("ovf_show%0d", i), mk(0, 4'b0010, 0, 5, 0, 0, 0, 0, 120, 1, 2, 0, OVF1));
    run_vec("ovf_blank", mk(0, 4'b0010, 0, 5, 0, 0, 0, 0, 120, 1, 0, 1, OVF1));
    run_vec("ovf_ld5",   mk(0, 4'b0010, 0, 5, 0, 0, 0, 0, 120, 1, 0, 1, OVF1));
    run_vec("ovf_keep",  mk(0, 4'b0010, 0, 5, 0, 0, 0, 0,   5, 1, 2, 0, OVF1));
    run_vec("ovf_clr",   mk(0, 4'b0010, 0, 5, 0, 0, 0, 1,   5, 1, 2, 0, 4'b0000));
    for (int i = 0; i < 2; i++)
      run_vec($sformatf("ovf_s%0d", i), mk(0, 4'b0010, 0, 120, 0, 0, 0, 0, 5, 1, 2, 0, 4'b0000));
    run_vec("ovf_bl2",   mk(0, 4'b0010, 0, 120, 0, 0, 0, 0, 5, 1, 0, 1, 4'b0000));
    run_vec("ovf_ld2",   mk(0, 4'b0010, 0, 120, 0, 0, 0, 0, 5, 1, 0, 1, 4'b0000));
    run_vec("ovf_setclr", mk(0, 4'b0010, 0, 120, 0, 0, 0, 1, 120, 1, 2, 0, OVF1));
    run_vec("rst_mid",   mk(1, 4'b0010, 0, 120, 0, 0, 0, 0,   0, 0, 0, 1, 4'b0000));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
